iic_xfer_seq: RTL and testbench

//  Transaction sequencer in front of iic_core. Takes one register-style I2C command
//  (device addr, register addr, write or read, length) and drives iic_core one byte op
//  at a time: START+dev/W, reg, [Sr+dev/R], data bytes, STOP.

---
 rtl/iic_xfer_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_iic_xfer_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_xfer_seq.sv
// Register-style I2C transaction sequencer: turns one command (dev, reg, dir, len)
// into a series of single-byte operations for iic_core, with NACK/timeout abort.
module iic_xfer_seq #(
  parameter int LEN_W   = 4,
  parameter int TMO_CYC = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_dev,
  input  logic [7:0]       cmd_reg,
  input  logic             cmd_rd,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic [1:0]       err,
  output logic             core_go,
  output logic             core_start,
  output logic             core_stop,
  output logic             core_bare,
  output logic             core_rw,
  output logic             core_last,
  output logic [7:0]       core_din,
  input  logic [7:0]       core_dout,
  input  logic             core_nack,
  input  logic             core_busy
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [3:0] {
    IDLE, DEVW, REG, RSDEV, WDATA, RDATA, WAIT, RDOUT, ABORT, FIN
  } state_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       bare;
    logic       rw;
    logic       last;
    logic [7:0] din;
  } op_t;

  localparam op_t OP_NONE = op_t'(13'd0);

  function automatic op_t mk_op(input logic start, input logic stop, input logic bare,
                                input logic rw, input logic last, input logic [7:0] din);
    op_t o;
    o.start = start;
    o.stop  = stop;
    o.bare  = bare;
    o.rw    = rw;
    o.last  = last;
    o.din   = din;
    return o;
  endfunction

  state_t             state_r, state_s;
  state_t             ret_r, ret_s;
  logic [6:0]         dev_r;
  logic [7:0]         reg_r;
  logic               rd_r;
  logic [LEN_W-1:0]   cnt_r, cnt_s;
  logic [1:0]         err_code_r, err_code_s;
  logic [TMO_W-1:0]   tmo_r, tmo_s;
  logic               seen_r, seen_s;
  op_t                op_r, op_s;
  logic               go_r, issue_s;
  logic               latch_s;
  logic               tmo_hit_s;
  logic               wr_ready_s;
  logic               cmd_ready_r;
  logic               rd_valid_r;
  logic [7:0]         rd_data_r, rd_data_s;
  logic               done_r;
  logic [1:0]         err_r;

  // Next-state, byte-op selection and bookkeeping updates
  always_comb begin
    state_s    = state_r;
    ret_s      = ret_r;
    cnt_s      = cnt_r;
    err_code_s = err_code_r;
    tmo_s      = tmo_r;
    seen_s     = seen_r;
    op_s       = op_r;
    issue_s    = 1'b0;
    latch_s    = 1'b0;
    wr_ready_s = 1'b0;
    rd_data_s  = rd_data_r;
    tmo_hit_s  = (tmo_r >= TMO_LAST);

    case (state_r)
      IDLE: begin
        err_code_s = 2'd0;
        if (cmd_valid) begin
          latch_s = 1'b1;
          cnt_s   = cmd_len;
          if (cmd_len == LEN_ZERO) begin
            err_code_s = 2'd3;
            state_s    = FIN;
          end else begin
            state_s = DEVW;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DEVW: begin
        issue_s = 1'b1;
        op_s    = mk_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {dev_r, 1'b0});
      end
      REG: begin
        issue_s = 1'b1;
        op_s    = mk_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, reg_r);
      end
      RSDEV: begin
        issue_s = 1'b1;
        op_s    = mk_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {dev_r, 1'b1});
      end
      WDATA: begin
        if (wr_valid) begin
          wr_ready_s = 1'b1;
          issue_s    = 1'b1;
          op_s       = mk_op(1'b0, cnt_r == LEN_ONE, 1'b0, 1'b0, 1'b0, wr_data);
        end else begin
          state_s = WDATA;
        end
      end
      RDATA: begin
        issue_s = 1'b1;
        op_s    = mk_op(1'b0, cnt_r == LEN_ONE, 1'b0, 1'b1, cnt_r == LEN_ONE, 8'h00);
      end
      WAIT: begin
        seen_s = seen_r | core_busy;
        tmo_s  = tmo_hit_s ? tmo_r : tmo_r + TMO_ONE;
        if (seen_r && !core_busy) begin
          case (ret_r)
            ABORT: state_s = FIN;
            RDATA: begin
              cnt_s     = cnt_r - LEN_ONE;
              rd_data_s = core_dout;
              state_s   = RDOUT;
            end
            default: begin
              if (core_nack) begin
                // STOP already went out with the last write byte, so no bare STOP
                err_code_s = 2'd1;
                state_s    = op_r.stop ? FIN : ABORT;
              end else begin
                case (ret_r)
                  DEVW:    state_s = REG;
                  REG:     state_s = rd_r ? RSDEV : WDATA;
                  RSDEV:   state_s = RDATA;
                  WDATA: begin
                    cnt_s   = cnt_r - LEN_ONE;
                    state_s = (cnt_r == LEN_ONE) ? FIN : WDATA;
                  end
                  default: state_s = FIN;
                endcase
              end
            end
          endcase
        end else if (tmo_hit_s) begin
          if (ret_r == ABORT) begin
            state_s = FIN;
          end else begin
            err_code_s = 2'd2;
            state_s    = ABORT;
          end
        end else begin
          state_s = WAIT;
        end
      end
      RDOUT: begin
        if (rd_ready) begin
          state_s = (cnt_r == LEN_ZERO) ? FIN : RDATA;
        end else begin
          state_s = RDOUT;
        end
      end
      ABORT: begin
        issue_s = 1'b1;
        op_s    = mk_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase

    // The abort op keeps the running timeout count so a hung bus cannot re-arm it
    if (issue_s) begin
      state_s = WAIT;
      ret_s   = state_r;
      seen_s  = 1'b0;
      tmo_s   = (state_r == ABORT) ? tmo_r : {TMO_W{1'b0}};
    end else begin
      ret_s = ret_r;
    end
  end

  // State, command fields, op fields and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ret_r       <= IDLE;
      dev_r       <= 7'd0;
      reg_r       <= 8'd0;
      rd_r        <= 1'b0;
      cnt_r       <= {LEN_W{1'b0}};
      err_code_r  <= 2'd0;
      tmo_r       <= {TMO_W{1'b0}};
      seen_r      <= 1'b0;
      op_r        <= OP_NONE;
      go_r        <= 1'b0;
      cmd_ready_r <= 1'b1;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= 8'h00;
      done_r      <= 1'b0;
      err_r       <= 2'd0;
    end else begin
      state_r     <= state_s;
      ret_r       <= ret_s;
      cnt_r       <= cnt_s;
      err_code_r  <= err_code_s;
      tmo_r       <= tmo_s;
      seen_r      <= seen_s;
      op_r        <= op_s;
      go_r        <= issue_s;
      cmd_ready_r <= (state_s == IDLE);
      rd_valid_r  <= (state_s == RDOUT);
      rd_data_r   <= rd_data_s;
      done_r      <= (state_r == FIN);
      err_r       <= (state_r == FIN) ? err_code_r : 2'd0;
      if (latch_s) begin
        dev_r <= cmd_dev;
        reg_r <= cmd_reg;
        rd_r  <= cmd_rd;
      end
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign wr_ready   = wr_ready_s;
  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_data_r;
  assign done       = done_r;
  assign err        = err_r;
  assign core_go    = go_r;
  assign core_start = op_r.start;
  assign core_stop  = op_r.stop;
  assign core_bare  = op_r.bare;
  assign core_rw    = op_r.rw;
  assign core_last  = op_r.last;
  assign core_din   = op_r.din;

endmodule

// File: tb/tb_iic_xfer_seq.sv
// Scoreboard bench for iic_xfer_seq: a transaction-level reference model predicts the
// byte-op sequence, read bytes and error code; a monitor compares what the DUT presents.
module tb_iic_xfer_seq;
  localparam int LEN_W = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             cmd_valid, cmd_ready, cmd_rd;
  logic [6:0]       cmd_dev;
  logic [7:0]       cmd_reg;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid, wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid, rd_ready;
  logic [7:0]       rd_data;
  logic             done;
  logic [1:0]       err;
  logic             core_go, core_start, core_stop, core_bare, core_rw, core_last;
  logic [7:0]       core_din, core_dout;
  logic             core_nack, core_busy;

  iic_xfer_seq #(.LEN_W(LEN_W), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg),
    .cmd_rd(cmd_rd), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .core_go(core_go), .core_start(core_start), .core_stop(core_stop), .core_bare(core_bare),
    .core_rw(core_rw), .core_last(core_last), .core_din(core_din),
    .core_dout(core_dout), .core_nack(core_nack), .core_busy(core_busy)
  );

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       bare;
    logic       rw;
    logic       last;
    logic [7:0] din;
  } op_t;

  typedef struct packed {
    logic       nack;
    logic       stuck;
    logic [7:0] dout;
  } resp_t;

  op_t        exp_ops[$];
  logic [7:0] exp_rd[$];
  logic [1:0] exp_err[$];
  resp_t      resp_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] t_wd[16];
  logic [7:0] t_rb[16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, go_cnt = 0;
  int done_cyc = 0, last_go_cyc = 0, prev_go_cyc = 0, acc_cyc = 0;
  bit stall_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues an op, hands over a byte or finishes
  initial begin
    op_t e;
    logic [7:0] b;
    logic [1:0] ee;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (core_go) begin
          go_cnt++;
          prev_go_cyc = last_go_cyc;
          last_go_cyc = cyc;
          chk("go_while_rd_pending", rd_valid, 0);
          if (exp_ops.size() == 0) begin
            fail_now("unexpected_core_go");
          end else begin
            e = exp_ops.pop_front();
            chk("op_start", core_start, e.start);
            chk("op_stop", core_stop, e.stop);
            chk("op_bare", core_bare, e.bare);
            chk("op_rw", core_rw, e.rw);
            chk("op_last", core_last, e.last);
            if (!e.rw && !e.bare) chk("op_din", core_din, e.din);
          end
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) begin
            fail_now("unexpected_rd_byte");
          end else begin
            b = exp_rd.pop_front();
            chk("rd_data", rd_data, b);
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_err.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            ee = exp_err.pop_front();
            chk("done_err", err, ee);
          end
        end
      end
    end
  end

  // Behavioural iic_core: busy rises 1..3 cycles after go, result appears as busy falls
  initial begin
    resp_t r;
    int d, k;
    core_busy = 1'b0;
    core_dout = 8'h00;
    core_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (core_go && !reset) begin
        if (resp_q.size() > 0) r = resp_q.pop_front();
        else r = '0;
        d = $urandom_range(1, 3);
        repeat (d) @(posedge clk);
        #1 core_busy = 1'b1;
        k = r.stuck ? TMO + 8 : $urandom_range(1, 4);
        repeat (k) @(posedge clk);
        #1;
        core_busy = 1'b0;
        core_dout = r.dout;
        core_nack = r.nack;
      end
    end
  end

  // Write-data source with random gaps
  initial begin
    bit take;
    logic [7:0] tmp;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    forever begin
      @(negedge clk);
      take = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (take && wr_q.size() > 0) tmp = wr_q.pop_front();
      if (wr_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        wr_valid = 1'b1;
        wr_data  = wr_q[0];
      end else begin
        wr_valid = 1'b0;
      end
    end
  end

  // Read-data sink: random back-pressure, or a 20-cycle stall on request
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && rd_valid) begin
        rd_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rd_valid_held_in_stall", rd_valid, 1);
        stall_req = 1'b0;
      end else begin
        rd_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Reference: the j-th byte op of a transaction
  function automatic op_t op_of(input int j, input logic [6:0] dev, input logic [7:0] rg,
                                input logic rd, input int len);
    op_t o;
    int nb, i;
    o  = '0;
    nb = rd ? 3 : 2;
    if (j == 0) begin
      o.start = 1'b1;
      o.din   = {dev, 1'b0};
    end else if (j == 1) begin
      o.din = rg;
    end else if (rd && j == 2) begin
      o.start = 1'b1;
      o.din   = {dev, 1'b1};
    end else begin
      i      = j - nb;
      o.stop = (i == len - 1);
      if (rd) begin
        o.rw   = 1'b1;
        o.last = (i == len - 1);
      end else begin
        o.din = t_wd[i];
      end
    end
    return o;
  endfunction

  task automatic recover();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_ops.delete(); exp_rd.delete(); exp_err.delete(); resp_q.delete(); wr_q.delete();
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((!cmd_ready || core_busy) && w < 500) begin
      @(posedge clk);
      #1 w++;
    end
    if (w >= 500) fail_now("idle_wait_timeout");
  endtask

  task automatic send_cmd(input logic [6:0] dev, input logic [7:0] rg, input logic rd,
                          input int len);
    cmd_dev   = dev;
    cmd_reg   = rg;
    cmd_rd    = rd;
    cmd_len   = LEN_W'(len);
    cmd_valid = 1'b1;
    acc_cyc   = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // kind: 0 clean, 1 NACK on op f, 2 busy stuck on op f
  task automatic run_txn(input logic [6:0] dev, input logic [7:0] rg, input logic rd,
                         input int len, input int kind, input int f);
    int nb, total, last_op, w, nd;
    op_t o;
    resp_t r;
    wait_idle();
    nb    = rd ? 3 : 2;
    total = nb + len;
    o     = '0;
    if (len == 0) begin
      exp_err.push_back(2'd3);
    end else begin
      last_op = (kind == 0) ? total - 1 : f;
      for (int j = 0; j <= last_op; j++) begin
        o = op_of(j, dev, rg, rd, len);
        exp_ops.push_back(o);
        r.nack  = (kind == 1 && j == f);
        r.stuck = (kind == 2 && j == f);
        r.dout  = (rd && j >= nb) ? t_rb[j - nb] : 8'h00;
        resp_q.push_back(r);
        if (rd && j >= nb && !(kind == 2 && j == f)) exp_rd.push_back(t_rb[j - nb]);
      end
      if ((kind == 1 && !o.stop) || kind == 2) begin
        exp_ops.push_back(op_t'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}));
        if (kind == 1) resp_q.push_back('0);
      end
      exp_err.push_back(kind == 0 ? 2'd0 : (kind == 1 ? 2'd1 : 2'd2));
      if (!rd) for (int i = 0; i < len; i++) wr_q.push_back(t_wd[i]);
    end
    nd = done_cnt;
    send_cmd(dev, rg, rd, len);
    w = 0;
    while (done_cnt == nd && w < 3000) begin
      @(posedge clk);
      w++;
    end
    if (done_cnt == nd) begin
      fail_now("done_timeout");
      recover();
    end else begin
      @(negedge clk);
      chk("ops_drained", exp_ops.size(), 0);
      chk("rd_drained", exp_rd.size(), 0);
      if (len == 0) chk("len0_done_latency", done_cyc - acc_cyc, 2);
      wr_q.delete();
      resp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_core_go"}, core_go, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_op_fields"}, {core_start, core_stop, core_bare, core_rw, core_last, core_din}, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, w, nd, len, kind, f, total;
    logic rd;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_dev = 7'd0; cmd_reg = 8'd0; cmd_rd = 1'b0; cmd_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Write 0x50/0x10, A5 3C
    t_wd[0] = 8'hA5; t_wd[1] = 8'h3C;
    run_txn(7'h50, 8'h10, 1'b0, 2, 0, 0);
    // Read 0x50/0x00, three bytes
    t_rb[0] = 8'h11; t_rb[1] = 8'h22; t_rb[2] = 8'h33;
    run_txn(7'h50, 8'h00, 1'b1, 3, 0, 0);
    // NACK on the device byte
    t_wd[0] = 8'h77;
    run_txn(7'h2A, 8'h05, 1'b0, 1, 1, 0);
    // Busy stuck on the first op: abort must come after the timeout
    run_txn(7'h33, 8'h44, 1'b0, 1, 2, 0);
    g = last_go_cyc - prev_go_cyc;
    chk("tmo_abort_delay_in_window", (g >= TMO && g <= TMO + 2), 1);
    // Illegal length
    run_txn(7'h10, 8'h20, 1'b0, 0, 0, 0);
    // Read with a 20-cycle consumer stall on the first byte
    t_rb[0] = 8'hC1; t_rb[1] = 8'hC2;
    stall_req = 1'b1;
    run_txn(7'h61, 8'h7E, 1'b1, 2, 0, 0);
    stall_req = 1'b0;

    // Reset while waiting on the first op: nothing else may come out
    wait_idle();
    exp_ops.push_back(op_of(0, 7'h22, 8'h01, 1'b1, 2));
    resp_q.push_back('0);
    g = go_cnt;
    send_cmd(7'h22, 8'h01, 1'b1, 2);
    w = 0;
    while (go_cnt == g && w < 50) begin
      @(posedge clk);
      w++;
    end
    if (go_cnt == g) fail_now("reset_test_no_first_op");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    nd = done_cnt;
    repeat (30) @(posedge clk);
    chk("no_done_after_midreset", done_cnt, nd);
    chk("midreset_ops_drained", exp_ops.size(), 0);
    resp_q.delete();

    // Randomised transactions
    for (int t = 0; t < 40; t++) begin
      rd  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      for (int i = 0; i < 16; i++) begin
        t_wd[i] = 8'($urandom);
        t_rb[i] = 8'($urandom);
      end
      total = (rd ? 3 : 2) + len;
      g = $urandom_range(0, 9);
      kind = (len == 0) ? 0 : (g < 6 ? 0 : (g < 8 ? 1 : 2));
      f = 0;
      if (kind == 1) f = rd ? $urandom_range(0, 2) : $urandom_range(0, total - 1);
      if (kind == 2) f = $urandom_range(0, total - 1);
      stall_req = rd && ($urandom_range(0, 3) == 0);
      run_txn(7'($urandom), 8'($urandom), rd, len, kind, f);
      stall_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
